// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, register counts and named register indices for the MIPS datapath.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_SP = 5'd29;
  localparam reg_idx_t REG_RA = 5'd31;
endpackage

// File: rtl/mux2_32.sv
// mux2_32: 32-bit 2:1 multiplexer cell, b selected when sel is high.
module mux2_32
  import mips_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/reg32_en.sv
// reg32_en: 32-bit register with synchronous load enable and asynchronous active-low clear.
module reg32_en
  import mips_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/mips_register_file.sv
// mips_register_file: 32x32 register file, two combinational read ports, one synchronous write port.
// $0 has no storage and reads as constant zero; reads never bypass the pending write.
module mips_register_file #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::REG_ADDR_W,
  parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:1] we;
  logic [DATA_W-1:0] rd [2];
  assign regs[0] = '0;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    assign we[i] = reg_write && write_reg == ADDR_W'(i);
    reg32_en #(.W(DATA_W)) u_reg (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (we[i]),
      .d    (write_data),
      .q    (regs[i])
    );
  end
  // Each read port is a 5-level binary tree of 2:1 cells, level l steered by index bit l.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [ADDR_W-1:0] sel;
    assign sel = (p == 0) ? read_reg1 : read_reg2;
    for (genvar l = 0; l < ADDR_W; l++) begin : g_lvl
      logic [DATA_W-1:0] y [NUM_REGS>>(l+1)];
      for (genvar j = 0; j < (NUM_REGS >> (l + 1)); j++) begin : g_cell
        if (l == 0) begin : g_leaf
          mux2_32 #(.W(DATA_W)) u_mux (
            .sel(sel[0]),
            .a  (regs[2*j]),
            .b  (regs[2*j+1]),
            .y  (y[j])
          );
        end else begin : g_node
          mux2_32 #(.W(DATA_W)) u_mux (
            .sel(sel[l]),
            .a  (g_lvl[l-1].y[2*j]),
            .b  (g_lvl[l-1].y[2*j+1]),
            .y  (y[j])
          );
        end
      end
    end
    assign rd[p] = g_lvl[ADDR_W-1].y[0];
  end
  assign read_data1 = rd[0];
  assign read_data2 = rd[1];
endmodule

// File: tb/tb_mips_register_file.sv
// tb_mips_register_file: directed and random checks of the register file against an array model.
module tb_mips_register_file;
  logic clk = 0, rst_n = 0, reg_write = 0;
  logic [4:0] read_reg1 = 0, read_reg2 = 0, write_reg = 0;
  logic [31:0] write_data = 0, read_data1, read_data2;
  logic [31:0] model [32];
  int checks = 0, passes = 0;

  always #5 clk = ~clk;

  mips_register_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_write (reg_write),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .write_reg (write_reg),
    .write_data(write_data),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [4:0] r2, input string tag);
    @(negedge clk);
    reg_write = 1; write_reg = a; write_data = d; read_reg1 = a; read_reg2 = r2;
    #1;
    chk({tag, " pre rd1"}, read_data1, model[a]);
    chk({tag, " pre rd2"}, read_data2, model[r2]);
    @(posedge clk);
    if (a != 0) model[a] = d;
    #1;
    chk({tag, " post rd1"}, read_data1, model[a]);
    chk({tag, " post rd2"}, read_data2, model[r2]);
    reg_write = 0;
  endtask

  task automatic check_all(input string tag);
    reg_write = 0;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
      #1;
      chk($sformatf("%s rd1[%0d]", tag, i), read_data1, model[i]);
      chk($sformatf("%s rd2[%0d]", tag, 31 - i), read_data2, model[31-i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] idx [3];
    idx[0] = 5'd0; idx[1] = 5'd5; idx[2] = 5'd31;
    clear_model();
    reg_write = 1; write_reg = 5'd5; write_data = 32'hDEAD_BEEF;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) begin
        read_reg1 = idx[k]; read_reg2 = idx[k];
        #1;
        chk($sformatf("reset rd1[%0d]", idx[k]), read_data1, 32'h0);
        chk($sformatf("reset rd2[%0d]", idx[k]), read_data2, 32'h0);
      end
      @(negedge clk);
    end
    reg_write = 0;
    rst_n = 1;
    check_all("after reset");
    wr(5'd8, 32'h1234_5678, 5'd9, "basic");
    wr(5'd0, 32'hFFFF_FFFF, 5'd0, "zero");
    wr(5'd17, 32'hA, 5'd17, "bypass setup");
    wr(5'd17, 32'hB, 5'd17, "no bypass");
    repeat (40) begin
      @(negedge clk);
      reg_write = 1'($urandom_range(0, 1));
      write_reg = 5'($urandom); write_data = $urandom;
      read_reg1 = 5'($urandom); read_reg2 = 5'($urandom);
      #1;
      chk("rand pre rd1", read_data1, model[read_reg1]);
      chk("rand pre rd2", read_data2, model[read_reg2]);
      @(posedge clk);
      if (reg_write && write_reg != 0) model[write_reg] = write_data;
      #1;
      chk("rand post rd1", read_data1, model[read_reg1]);
      chk("rand post rd2", read_data2, model[read_reg2]);
    end
    reg_write = 0;
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 3), 5'($urandom), "load");
    repeat (10) begin
      @(negedge clk);
      reg_write = 0; write_reg = 5'($urandom); write_data = $urandom;
    end
    check_all("gated");
    @(negedge clk);
    write_reg = 'x; write_data = 'x;
    @(posedge clk);
    #1;
    check_all("x index idle");
    @(negedge clk);
    read_reg1 = 5'd31; read_reg2 = 5'd3;
    #1 rst_n = 0;
    #1;
    chk("async reset rd1[31]", read_data1, 32'h0);
    chk("async reset rd2[3]", read_data2, 32'h0);
    #2 rst_n = 1;
    clear_model();
    check_all("after pulse");
    wr(5'd31, 32'h0040_0008, 5'd31, "post-reset write");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
